// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer running on the board reference clock.
// Holds the PLL in reset, waits for a stable synchronized LOCK, then releases the
// system reset. Lock timeouts retry a bounded number of times before failing;
// loss of lock while running restarts the whole sequence.
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES         = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT       = 65535,
   parameter int unsigned MAX_RETRIES        = 3
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       lock_i,
   input  logic       restart_i,
   output logic       pll_reset_o,
   output logic       sys_rstn_o,
   output logic       locked_o,
   output logic       fail_o,
   output logic       lock_lost_o,
   output logic [7:0] retry_cnt_o
);

   // One counter is shared by all timed states, so it is sized for the longest.
   localparam int unsigned CntMaxA = (RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                     RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned CntMax  = (CntMaxA > LOCK_TIMEOUT) ? CntMaxA : LOCK_TIMEOUT;
   localparam int unsigned CntW    = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
   localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CntW-1:0] ToLast     = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [7:0]      MaxRetries = 8'(MAX_RETRIES);

   localparam logic [2:0] StResetPll = 3'd0;
   localparam logic [2:0] StWaitLock = 3'd1;
   localparam logic [2:0] StStable   = 3'd2;
   localparam logic [2:0] StRun      = 3'd3;
   localparam logic [2:0] StFail     = 3'd4;

   logic            sync1_q, lock_s_q;
   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      retry_q, retry_d;
   logic            pll_reset_q, pll_reset_d;
   logic            sys_rstn_q, sys_rstn_d;
   logic            locked_q, locked_d;
   logic            fail_q, fail_d;
   logic            lost_q, lost_d;

   // Two-flop synchronizer for the asynchronous PLL LOCK signal.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= lock_i;
         lock_s_q <= sync1_q;
      end
   end

   // Next-state logic; outputs are derived from the next state so they are registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      retry_d = retry_q;
      lost_d  = 1'b0;
      if (restart_i) begin
         state_d = StResetPll;
         cnt_d   = '0;
         retry_d = '0;
      end else begin
         case (state_q)
            StResetPll: begin
               if (cnt_q == RstLast) begin
                  state_d = StWaitLock;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StWaitLock: begin
               // Lock wins over a coinciding timeout.
               if (lock_s_q) begin
                  state_d = StStable;
                  cnt_d   = '0;
               end else if (cnt_q == ToLast) begin
                  cnt_d = '0;
                  if (retry_q == MaxRetries) begin
                     state_d = StFail;
                  end else begin
                     retry_d = retry_q + 8'd1;
                     state_d = StResetPll;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StStable: begin
               // A lock dropout restarts the stability window but is not a failed attempt.
               if (!lock_s_q) begin
                  state_d = StWaitLock;
                  cnt_d   = '0;
               end else if (cnt_q == StableLast) begin
                  state_d = StRun;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StRun: begin
               if (!lock_s_q) begin
                  state_d = StResetPll;
                  cnt_d   = '0;
                  retry_d = '0;
                  lost_d  = 1'b1;
               end
            end
            StFail: begin
               state_d = StFail;
            end
            default: begin
               state_d = StResetPll;
               cnt_d   = '0;
            end
         endcase
      end

      pll_reset_d = (state_d == StResetPll) || (state_d == StFail);
      sys_rstn_d  = (state_d == StRun);
      locked_d    = (state_d == StRun);
      fail_d      = (state_d == StFail);
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StResetPll;
         cnt_q       <= '0;
         retry_q     <= '0;
         pll_reset_q <= 1'b1;
         sys_rstn_q  <= 1'b0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
         lost_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         pll_reset_q <= pll_reset_d;
         sys_rstn_q  <= sys_rstn_d;
         locked_q    <= locked_d;
         fail_q      <= fail_d;
         lost_q      <= lost_d;
      end
   end

   assign pll_reset_o = pll_reset_q;
   assign sys_rstn_o  = sys_rstn_q;
   assign locked_o    = locked_q;
   assign fail_o      = fail_q;
   assign lock_lost_o = lost_q;
   assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/elapsed-time reference model
// pushes the expected output set each clock; a monitor pops and compares.
module tb_pll_lock_sequencer;

   localparam int unsigned RST_CYCLES         = 4;
   localparam int unsigned LOCK_STABLE_CYCLES = 8;
   localparam int unsigned LOCK_TIMEOUT       = 32;
   localparam int unsigned MAX_RETRIES        = 2;

   localparam int PH_HOLD   = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_RUN    = 3;
   localparam int PH_FAIL   = 4;

   localparam int SEL_PLLRST = 0;
   localparam int SEL_LOCKED = 1;
   localparam int SEL_FAIL   = 2;

   logic       clk;
   logic       rstn;
   logic       lock_i;
   logic       restart_i;
   logic       pll_reset_o, sys_rstn_o, locked_o, fail_o, lock_lost_o;
   logic [7:0] retry_cnt_o;
   logic [12:0] dut_vec;

   int total = 0;
   int bad   = 0;

   logic [12:0] exp_q[$];

   // Reference model state.
   int   m_ph      = PH_HOLD;
   int   m_t       = 0;
   int   m_retries = 0;
   bit   m_lost    = 1'b0;
   bit   m_p1      = 1'b0;
   bit   m_p2      = 1'b0;

   pll_lock_sequencer #(
      .RST_CYCLES        (RST_CYCLES),
      .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
      .LOCK_TIMEOUT      (LOCK_TIMEOUT),
      .MAX_RETRIES       (MAX_RETRIES)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .lock_i     (lock_i),
      .restart_i  (restart_i),
      .pll_reset_o(pll_reset_o),
      .sys_rstn_o (sys_rstn_o),
      .locked_o   (locked_o),
      .fail_o     (fail_o),
      .lock_lost_o(lock_lost_o),
      .retry_cnt_o(retry_cnt_o)
   );

   assign dut_vec = {pll_reset_o, sys_rstn_o, locked_o, fail_o, lock_lost_o, retry_cnt_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [12:0] model_outputs();
      logic [7:0] r;
      r = 8'(m_retries);
      return {(m_ph == PH_HOLD) || (m_ph == PH_FAIL), m_ph == PH_RUN, m_ph == PH_RUN,
              m_ph == PH_FAIL, m_lost, r};
   endfunction

   task automatic model_reset();
      m_ph      = PH_HOLD;
      m_t       = 0;
      m_retries = 0;
      m_lost    = 1'b0;
      m_p1      = 1'b0;
      m_p2      = 1'b0;
   endtask

   // One clock of the reference model: LOCK is seen two edges after it is sampled.
   task automatic model_step();
      bit seen;
      if (!rstn) begin
         model_reset();
         exp_q.push_back(model_outputs());
         return;
      end
      seen   = m_p2;
      m_p2   = m_p1;
      m_p1   = lock_i;
      m_lost = 1'b0;
      if (restart_i) begin
         m_ph      = PH_HOLD;
         m_t       = 0;
         m_retries = 0;
      end else begin
         case (m_ph)
            PH_HOLD: begin
               m_t++;
               if (m_t == RST_CYCLES) begin
                  m_ph = PH_WAIT;
                  m_t  = 0;
               end
            end
            PH_WAIT: begin
               if (seen) begin
                  m_ph = PH_STABLE;
                  m_t  = 0;
               end else begin
                  m_t++;
                  if (m_t == LOCK_TIMEOUT) begin
                     m_t = 0;
                     if (m_retries == MAX_RETRIES) m_ph = PH_FAIL;
                     else begin
                        m_retries++;
                        m_ph = PH_HOLD;
                     end
                  end
               end
            end
            PH_STABLE: begin
               if (!seen) begin
                  m_ph = PH_WAIT;
                  m_t  = 0;
               end else begin
                  m_t++;
                  if (m_t == LOCK_STABLE_CYCLES) m_ph = PH_RUN;
               end
            end
            PH_RUN: begin
               if (!seen) begin
                  m_ph      = PH_HOLD;
                  m_t       = 0;
                  m_retries = 0;
                  m_lost    = 1'b1;
               end
            end
            default: ;
         endcase
      end
      exp_q.push_back(model_outputs());
   endtask

   // Model advances on every active edge.
   always @(posedge clk) model_step();

   // Asynchronous reset clears the model immediately.
   always @(negedge rstn) model_reset();

   // Monitor: compare the registered outputs just after each edge.
   always @(posedge clk) begin
      logic [12:0] e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         total++;
         if (dut_vec !== e) begin
            bad++;
            $display("FAIL outputs t=%0t got=%b want=%b (pll,sys,lk,fail,lost,retry)",
                     $time, dut_vec, e);
         end
      end
      total++;
      if ((sys_rstn_o && (!locked_o || pll_reset_o)) || (fail_o && locked_o)) begin
         bad++;
         $display("FAIL invariant t=%0t got=%b want=consistent", $time, dut_vec);
      end
   end

   function automatic logic get_sig(input int sel);
      case (sel)
         SEL_PLLRST: return pll_reset_o;
         SEL_LOCKED: return locked_o;
         default:    return fail_o;
      endcase
   endfunction

   // Bounded wait at negedges for a DUT output to reach a level.
   task automatic wait_sig(input int sel, input logic val, input int budget, input string name);
      int n;
      n = 0;
      while (get_sig(sel) !== val && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (get_sig(sel) !== val) begin
         bad++;
         $display("FAIL %s got=%b want=%b after %0d cycles", name, get_sig(sel), val, n);
      end
   endtask

   task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", name, got, want);
      end
   endtask

   initial begin
      int hold_left;
      rstn      = 1'b0;
      lock_i    = 1'b0;
      restart_i = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;

      // Nominal bring-up: lock arrives 10 cycles after PLL reset is released.
      wait_sig(SEL_PLLRST, 1'b0, 50, "nominal_pll_release");
      repeat (10) @(negedge clk);
      lock_i = 1'b1;
      wait_sig(SEL_LOCKED, 1'b1, 60, "nominal_locked");
      repeat (5) @(negedge clk);

      // Loss of lock in RUN, then relock.
      lock_i = 1'b0;
      wait_sig(SEL_PLLRST, 1'b1, 20, "loss_pll_reset");
      wait_sig(SEL_PLLRST, 1'b0, 20, "loss_pll_release");
      repeat (3) @(negedge clk);
      lock_i = 1'b1;
      wait_sig(SEL_LOCKED, 1'b1, 60, "loss_relock");

      // Lock glitch while STABLE.
      lock_i = 1'b0;
      wait_sig(SEL_PLLRST, 1'b1, 20, "glitch_pll_reset");
      wait_sig(SEL_PLLRST, 1'b0, 20, "glitch_pll_release");
      lock_i = 1'b1;
      repeat (5) @(negedge clk);
      lock_i = 1'b0;
      repeat (2) @(negedge clk);
      lock_i = 1'b1;
      wait_sig(SEL_LOCKED, 1'b1, 60, "glitch_relock");

      // Asynchronous reset in the middle of STABLE.
      lock_i = 1'b0;
      wait_sig(SEL_PLLRST, 1'b1, 20, "areset_pll_reset");
      wait_sig(SEL_PLLRST, 1'b0, 20, "areset_pll_release");
      lock_i = 1'b1;
      repeat (5) @(negedge clk);
      #2 rstn = 1'b0;
      #1 check("areset_immediate", dut_vec, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rstn = 1'b1;
      wait_sig(SEL_LOCKED, 1'b1, 80, "areset_relock");

      // Timeouts, retries and FAIL, then restart.
      lock_i = 1'b0;
      wait_sig(SEL_FAIL, 1'b1, 300, "timeout_fail");
      repeat (4) @(negedge clk);
      restart_i = 1'b1;
      @(negedge clk);
      restart_i = 1'b0;

      // Lock seen exactly on the timeout edge of the second attempt.
      wait_sig(SEL_PLLRST, 1'b0, 20, "coinc_first_release");
      wait_sig(SEL_PLLRST, 1'b1, 60, "coinc_retry_reset");
      wait_sig(SEL_PLLRST, 1'b0, 20, "coinc_second_release");
      repeat (LOCK_TIMEOUT - 3) @(negedge clk);
      lock_i = 1'b1;
      wait_sig(SEL_LOCKED, 1'b1, 60, "coinc_locked");
      check("coinc_retry_kept", {5'd0, retry_cnt_o}, 13'd1);

      // Restart on the cycle that would enter RUN.
      lock_i = 1'b0;
      wait_sig(SEL_PLLRST, 1'b1, 20, "rstrun_pll_reset");
      wait_sig(SEL_PLLRST, 1'b0, 20, "rstrun_pll_release");
      lock_i = 1'b1;
      repeat (LOCK_STABLE_CYCLES + 2) @(negedge clk);
      restart_i = 1'b1;
      @(negedge clk);
      restart_i = 1'b0;
      check("rstrun_held", {10'd0, sys_rstn_o, locked_o, pll_reset_o}, 13'b001);
      wait_sig(SEL_LOCKED, 1'b1, 60, "rstrun_relock");

      // Randomized lock activity with occasional restarts.
      hold_left = 0;
      repeat (600) begin
         @(negedge clk);
         if (hold_left == 0) begin
            lock_i    = ~lock_i;
            hold_left = $urandom_range(1, 45);
         end else begin
            hold_left--;
         end
         restart_i = ($urandom_range(0, 99) < 2);
      end
      restart_i = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
